bank_arb_resp_demux: RTL and testbench
======================================

BANK_ARB_RESP_DEMUX -- requirements
Module: bank_arb_resp_demux

Interface
REQ-001 SHALL have parameter NumIn, default 4, giving the number of master ports; legal values are 2 or more.
REQ-002 SHALL have parameter ReqDataWidth, default 32, giving the request payload width.
REQ-003 SHALL have parameter RespDataWidth, default 32, giving the response data width.
REQ-004 SHALL have parameter RespLat, default 1, giving the bank read latency in cycles; legal values are 1 or more.
REQ-005 SHALL have parameter WriteRespOn, default 1; when 1, writes also return a valid response.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port req_i, input, NumIn bits: per-master request.
REQ-009 SHALL have port wen_i, input, NumIn bits: per-master write enable.
REQ-010 SHALL have port data_i, input, NumIn x ReqDataWidth: per-master payload.
REQ-011 SHALL have port gnt_o, output, NumIn bits: per-master grant.
REQ-012 SHALL have port vld_o, output, NumIn bits: per-master response valid.
REQ-013 SHALL have port rdata_o, output, RespDataWidth: response data, shared by all masters.
REQ-014 SHALL have port req_o, output, 1 bit: request to the bank.
REQ-015 SHALL have port wen_o, output, 1 bit: write enable of the selected master.
REQ-016 SHALL have port data_o, output, ReqDataWidth: payload of the selected master.
REQ-017 SHALL have port gnt_i, input, 1 bit: bank accepts the request.
REQ-018 SHALL have port rdata_i, input, RespDataWidth: bank read data, valid RespLat cycles after the handshake.

Function
REQ-019 SHALL define IW as max(1, clog2(NumIn)) and hold a round-robin pointer rr_q that is IW bits wide.
REQ-020 SHALL select as winner the first index i with req_i[i]=1, searching from rr_q upward and wrapping from NumIn-1 to 0.
REQ-021 SHALL drive req_o as the OR of req_i; all outputs in this requirement are combinational.
- Winner payload: wen_o=wen_i[winner] and data_o=data_i[winner] whenever req_o=1.
- When req_o=0: wen_o=0 and data_o=0.
REQ-022 SHALL drive gnt_o[winner]=gnt_i&req_o and all other gnt_o bits 0; at most one gnt_o bit is set per cycle.
REQ-023 SHALL, on a handshake (req_o&gnt_i), load rr_q with (winner+1) mod NumIn; otherwise rr_q SHALL hold its value.
REQ-024 SHALL keep the same winner while the bank stalls (gnt_i=0), provided req_i is unchanged; rr_q does not advance.
REQ-025 SHALL treat a handshake as response-generating when wen_o=0, or when WriteRespOn=1.
REQ-026 SHALL pipeline the response valid and the winner index through RespLat register stages (vld_q, idx_q), shifting every cycle.
REQ-027 SHALL drive vld_o[idx_q[last]]=vld_q[last] and all other vld_o bits 0.
REQ-028 SHALL drive rdata_o=rdata_i unregistered, on all cycles.
REQ-029 SHALL accept one handshake per cycle; back-to-back responses SHALL emerge on consecutive cycles in handshake order.
REQ-030 SHALL allow a master's req_i to drop while it is the winner and gnt_i=0; the next request in round-robin order then wins with no penalty cycle.
REQ-031 SHALL stop simulation with a fatal error when NumIn<2 or RespLat<1; this check is simulation-only.

Reset
REQ-032 SHALL, while rst_i=1 and asynchronously, clear rr_q, vld_q and idx_q to 0.
REQ-033 SHALL hold vld_o=0 during reset; responses in flight when reset asserts are discarded.
REQ-034 SHALL, on the first cycle after reset release, give priority to index 0.

Verification (NumIn=4, RespLat=1, WriteRespOn=1 unless stated)
REQ-035 SHALL cover a single read: req_i=0100, wen_i=0, gnt_i=1 -> same cycle gnt_o=0100 and data_o=data_i[2]; next cycle vld_o=0100 and rdata_o=rdata_i.
REQ-036 SHALL cover fairness: req_i=1111 held with gnt_i=1 from reset -> gnt_o sequence is 0001, 0010, 0100, 1000, 0001.
REQ-037 SHALL cover a bank stall: req_i=1010 from reset, gnt_i=0 for 3 cycles -> req_o=1, data_o=data_i[1], gnt_o=0000 and rr_q=0 throughout; then gnt_i=1 -> gnt_o=0010 and rr_q becomes 2.
REQ-038 SHALL cover suppressed write responses: WriteRespOn=0, req_i=0001, wen_i=0001, gnt_i=1 -> gnt_o=0001, and vld_o stays 0000 for the next 4 cycles.
REQ-039 SHALL cover latency pipelining: RespLat=3, reads handshaken from masters 0, 1, 2 at cycles t, t+1, t+2 -> vld_o is 0001 at t+3, 0010 at t+4, 0100 at t+5, then 0000.
REQ-040 SHALL cover reset mid-flight: RespLat=2, read handshake at cycle t, rst_i pulsed high at t+1 -> vld_o is 0000 immediately and remains 0000 at t+2; after release, req_i=1111 grants index 0 first.

Source files
------------

// File: rtl/bank_arb_resp_demux_if.sv
// Bundle of the master-side request/response lines and the bank-side port
// of the round-robin bank arbiter with response demultiplexer.
interface bank_arb_resp_demux_if #(
  parameter int NumIn         = 4,
  parameter int ReqDataWidth  = 32,
  parameter int RespDataWidth = 32
);
  logic [NumIn-1:0]                   req_i;
  logic [NumIn-1:0]                   wen_i;
  logic [NumIn-1:0][ReqDataWidth-1:0] data_i;
  logic [NumIn-1:0]                   gnt_o;
  logic [NumIn-1:0]                   vld_o;
  logic [RespDataWidth-1:0]           rdata_o;
  logic                               req_o;
  logic                               wen_o;
  logic [ReqDataWidth-1:0]            data_o;
  logic                               gnt_i;
  logic [RespDataWidth-1:0]           rdata_i;

  modport slave (
    input  req_i, wen_i, data_i, gnt_i, rdata_i,
    output gnt_o, vld_o, rdata_o, req_o, wen_o, data_o
  );

  modport master (
    output req_i, wen_i, data_i, gnt_i, rdata_i,
    input  gnt_o, vld_o, rdata_o, req_o, wen_o, data_o
  );
endinterface

// File: rtl/bank_arb_resp_demux.sv
// Round-robin arbiter from NumIn masters onto one memory bank, with a
// RespLat-deep pipeline that routes each response valid back to its master.
module bank_arb_resp_demux #(
  parameter int NumIn         = 4,
  parameter int ReqDataWidth  = 32,
  parameter int RespDataWidth = 32,
  parameter int RespLat       = 1,
  parameter int WriteRespOn   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  bank_arb_resp_demux_if.slave  bus
);
  localparam int IW = (NumIn > 1) ? $clog2(NumIn) : 1;

  if (NumIn < 2 || RespLat < 1) begin : g_paramCheck
    $fatal(1, "bank_arb_resp_demux: illegal parameters NumIn=%0d RespLat=%0d", NumIn, RespLat);
  end

  logic [IW-1:0]              rr_q, rr_d;
  logic [IW-1:0]              winner;
  logic [IW-1:0]              winnerNext;
  logic                       found;
  int                         cand;
  logic                       anyReq;
  logic                       handshake;
  logic                       respGen;
  logic [RespLat-1:0]         vld_q, vld_d;
  logic [RespLat-1:0][IW-1:0] idx_q, idx_d;

  // Search upward from the pointer, wrapping, for the first requester.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NumIn; k++) begin
      cand = (int'(rr_q) + k) % NumIn;
      if (!found && bus.req_i[cand]) begin
        winner = IW'(cand);
        found  = 1'b1;
      end
    end
  end

  assign anyReq    = |bus.req_i;
  assign bus.req_o = anyReq;
  assign bus.wen_o  = anyReq ? bus.wen_i[winner]  : 1'b0;
  assign bus.data_o = anyReq ? bus.data_i[winner] : '0;

  always_comb begin
    bus.gnt_o         = '0;
    bus.gnt_o[winner] = bus.gnt_i & anyReq;
  end

  assign handshake  = anyReq & bus.gnt_i;
  assign respGen    = handshake & (~bus.wen_o | (WriteRespOn != 0));
  assign winnerNext = (winner == IW'(NumIn - 1)) ? '0 : winner + IW'(1);
  assign rr_d       = handshake ? winnerNext : rr_q;

  always_comb begin
    vld_d    = '0;
    idx_d    = '0;
    vld_d[0] = respGen;
    idx_d[0] = winner;
    for (int s = 1; s < RespLat; s++) begin
      vld_d[s] = vld_q[s-1];
      idx_d[s] = idx_q[s-1];
    end
  end

  // Reset drops any response still in the pipe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q  <= '0;
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      rr_q  <= rr_d;
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    bus.vld_o                     = '0;
    bus.vld_o[idx_q[RespLat-1]]   = vld_q[RespLat-1];
  end

  assign bus.rdata_o = bus.rdata_i;
endmodule

// File: tb/tb_bank_arb_resp_demux.sv
// Directed bench for bank_arb_resp_demux: a vector table on the default
// configuration plus short sequences on three other parameter sets.
module tb_bank_arb_resp_demux;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bank_arb_resp_demux_if #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32)) bus0 ();
  bank_arb_resp_demux_if #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32)) bus1 ();
  bank_arb_resp_demux_if #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32)) bus2 ();
  bank_arb_resp_demux_if #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32)) bus3 ();

  bank_arb_resp_demux #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32), .RespLat(1), .WriteRespOn(1))
    u0 (.clk_i(clk), .rst_i(rst), .bus(bus0.slave));
  bank_arb_resp_demux #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32), .RespLat(1), .WriteRespOn(0))
    u1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));
  bank_arb_resp_demux #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32), .RespLat(3), .WriteRespOn(1))
    u2 (.clk_i(clk), .rst_i(rst), .bus(bus2.slave));
  bank_arb_resp_demux #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32), .RespLat(2), .WriteRespOn(1))
    u3 (.clk_i(clk), .rst_i(rst), .bus(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] wen;
    logic       gnt;
    logic [3:0] expGnt;
    logic       expReq;
    logic       expWen;
    int         expSel;
    logic [3:0] expVld;
  } vec_t;

  vec_t vecs[9];
  logic [31:0] rdataVal;

  function automatic logic [31:0] dataOf(int k);
    return 32'hCAFE_0000 + 32'(k);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rdataVal      = $urandom;
    bus0.req_i    = v.req;
    bus0.wen_i    = v.wen;
    bus0.gnt_i    = v.gnt;
    bus0.rdata_i  = rdataVal;
  endtask

  task automatic idleAll();
    bus0.req_i = '0; bus0.wen_i = '0; bus0.gnt_i = 1'b0; bus0.rdata_i = '0;
    bus1.req_i = '0; bus1.wen_i = '0; bus1.gnt_i = 1'b0; bus1.rdata_i = '0;
    bus2.req_i = '0; bus2.wen_i = '0; bus2.gnt_i = 1'b0; bus2.rdata_i = '0;
    bus3.req_i = '0; bus3.wen_i = '0; bus3.gnt_i = 1'b0; bus3.rdata_i = '0;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    idleAll();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idleAll();
    for (int k = 0; k < 4; k++) begin
      bus0.data_i[k] = dataOf(k);
      bus1.data_i[k] = dataOf(k);
      bus2.data_i[k] = dataOf(k);
      bus3.data_i[k] = dataOf(k);
    end

    //            req      wen      gnt   expGnt   rq    wn    sel  expVld
    vecs[0] = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0,  2, 4'b0000};
    vecs[1] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, -1, 4'b0100};
    vecs[2] = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0,  3, 4'b0000};
    vecs[3] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1,  0, 4'b1000};
    vecs[4] = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0,  0, 4'b0001};
    vecs[5] = '{4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0,  1, 4'b0000};
    vecs[6] = '{4'b1001, 4'b1000, 1'b1, 4'b1000, 1'b1, 1'b1,  3, 4'b0010};
    vecs[7] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, -1, 4'b1000};
    vecs[8] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, -1, 4'b0000};

    @(negedge clk);
    checkOutput("reset vld_o", 32'(bus0.vld_o), 32'h0);
    checkOutput("reset rr_q", 32'(u0.rr_q), 32'h0);
    doReset();

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d gnt_o", i), 32'(bus0.gnt_o), 32'(vecs[i].expGnt));
      checkOutput($sformatf("v%0d req_o", i), 32'(bus0.req_o), 32'(vecs[i].expReq));
      checkOutput($sformatf("v%0d wen_o", i), 32'(bus0.wen_o), 32'(vecs[i].expWen));
      checkOutput($sformatf("v%0d data_o", i), bus0.data_o,
                  (vecs[i].expSel < 0) ? 32'h0 : dataOf(vecs[i].expSel));
      checkOutput($sformatf("v%0d vld_o", i), 32'(bus0.vld_o), 32'(vecs[i].expVld));
      checkOutput($sformatf("v%0d rdata_o", i), bus0.rdata_o, rdataVal);
    end

    // Fairness from reset with every master requesting.
    doReset();
    bus0.req_i = 4'b1111;
    bus0.gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("fair%0d gnt_o", i), 32'(bus0.gnt_o), 32'(4'b0001 << (i % 4)));
      @(posedge clk);
      #1;
    end

    // Bank stall: winner and pointer frozen until the grant arrives.
    doReset();
    bus0.req_i = 4'b1010;
    bus0.gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d req_o", i), 32'(bus0.req_o), 32'h1);
      checkOutput($sformatf("stall%0d data_o", i), bus0.data_o, dataOf(1));
      checkOutput($sformatf("stall%0d gnt_o", i), 32'(bus0.gnt_o), 32'h0);
      checkOutput($sformatf("stall%0d rr_q", i), 32'(u0.rr_q), 32'h0);
      @(posedge clk);
      #1;
    end
    bus0.gnt_i = 1'b1;
    @(negedge clk);
    checkOutput("stall gnt_o", 32'(bus0.gnt_o), 32'b0010);
    @(posedge clk);
    #1;
    bus0.req_i = '0;
    bus0.gnt_i = 1'b0;
    checkOutput("stall rr_q after", 32'(u0.rr_q), 32'h2);

    // Stalled winner withdraws; next requester takes over at once.
    doReset();
    bus0.req_i = 4'b0011;
    @(negedge clk);
    checkOutput("drop data_o before", bus0.data_o, dataOf(0));
    @(posedge clk);
    #1;
    bus0.req_i = 4'b0010;
    bus0.gnt_i = 1'b1;
    @(negedge clk);
    checkOutput("drop gnt_o", 32'(bus0.gnt_o), 32'b0010);
    checkOutput("drop data_o", bus0.data_o, dataOf(1));

    // Writes without response generation.
    doReset();
    bus1.req_i = 4'b0001;
    bus1.wen_i = 4'b0001;
    bus1.gnt_i = 1'b1;
    @(negedge clk);
    checkOutput("wr gnt_o", 32'(bus1.gnt_o), 32'b0001);
    @(posedge clk);
    #1;
    bus1.req_i = '0;
    bus1.wen_i = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("wr%0d vld_o", i), 32'(bus1.vld_o), 32'h0);
      @(posedge clk);
      #1;
    end
    bus1.req_i = 4'b0100;
    @(posedge clk);
    #1;
    bus1.req_i = '0;
    bus1.gnt_i = 1'b0;
    @(negedge clk);
    checkOutput("wr read vld_o", 32'(bus1.vld_o), 32'b0100);

    // Three-stage latency with back-to-back reads.
    doReset();
    bus2.gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus2.req_i = 4'(4'b0001 << i);
      @(negedge clk);
      checkOutput($sformatf("lat t%0d gnt_o", i), 32'(bus2.gnt_o), 32'(4'b0001 << i));
      checkOutput($sformatf("lat t%0d vld_o", i), 32'(bus2.vld_o), 32'h0);
      @(posedge clk);
      #1;
    end
    bus2.req_i = '0;
    bus2.gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("lat t%0d vld_o", i + 3), 32'(bus2.vld_o),
                  (i < 3) ? 32'(4'b0001 << i) : 32'h0);
      @(posedge clk);
      #1;
    end

    // Reset while a response is in flight.
    doReset();
    bus3.req_i = 4'b0001;
    bus3.gnt_i = 1'b1;
    @(negedge clk);
    checkOutput("rstmid gnt_o", 32'(bus3.gnt_o), 32'b0001);
    @(posedge clk);
    #1;
    bus3.req_i = '0;
    bus3.gnt_i = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rstmid t+1 vld_o", 32'(bus3.vld_o), 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("rstmid t+2 vld_o", 32'(bus3.vld_o), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus3.req_i = 4'b1111;
    bus3.gnt_i = 1'b1;
    @(negedge clk);
    checkOutput("rstmid first gnt_o", 32'(bus3.gnt_o), 32'b0001);
    @(posedge clk);
    #1;
    idleAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
